contador_cm_param: RTL

Parametrised echo-pulse distance meter for the ultrasonic sensor path, with datapath and control in one module.
- Generates its own time-base ticks from the system clock.
- Converts the width of the echo pulse into an N-digit packed-BCD centimetre count.
- Adds saturation, an overflow flag, rising-edge arming and a configurable ticks-per-cm ratio.
- Feeds the distance display/serial blocks through `digitos` and a one-cycle `pronto` strobe.

---
 rtl/contador_cm_param_pkg.sv | 34 +++
 rtl/contador_cm_param_bcd.sv | 41 ++++
 rtl/contador_cm_param.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/contador_cm_param_pkg.sv
// Shared state encodings, digit width and default timing for the echo distance meter.
// The optional rounding state is used only when CONTADOR_CM_ROUND_EN is defined.
package contador_cm_param_pkg;

  localparam int BCD_W            = 4;
  localparam int CLK_PER_TICK_DEF = 1470;
  localparam int TICKS_PER_CM_DEF = 2;
  localparam int N_DIGITS_DEF     = 3;
  localparam int MAX_CM_DEF       = 400;

  typedef enum logic [2:0] {
    INICIAL,
    PREPARACAO,
    CONTA,
    INCREMENTA,
    SATURADO,
    FINAL,
    ARREDONDA
  } estado_t;

  // Packs up to 8 decimal digits; callers keep only the digits they carry.
  function automatic logic [31:0] to_bcd32(input int unsigned valor);
    logic [31:0] r;
    int unsigned x;
    r = '0;
    x = valor;
    for (int i = 0; i < 8; i++) begin
      r[i*BCD_W +: BCD_W] = BCD_W'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

endpackage

// File: rtl/contador_cm_param_bcd.sv
// N-digit packed-BCD counter: synchronous clear, increment enable, ripple carry.
module bcd_counter_n
  import contador_cm_param_pkg::*;
#(
  parameter int N_DIGITS = N_DIGITS_DEF
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      clear,
  input  logic                      inc,
  output logic [BCD_W*N_DIGITS-1:0] valor
);

  logic [N_DIGITS-1:0] carry;

  assign carry[0] = inc;

  generate
    for (genvar gi = 0; gi < N_DIGITS; gi++) begin : g_digit
      logic [BCD_W-1:0] digit_reg;

      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          digit_reg <= '0;
        end else if (clear) begin
          digit_reg <= '0;
        end else if (carry[gi]) begin
          digit_reg <= (digit_reg == BCD_W'(9)) ? '0 : digit_reg + 1'b1;
        end
      end

      // The top digit's carry-out has nowhere to go; MAX_CM keeps us below it.
      if (gi < N_DIGITS - 1) begin : g_carry
        assign carry[gi+1] = carry[gi] && (digit_reg == BCD_W'(9));
      end

      assign valor[gi*BCD_W +: BCD_W] = digit_reg;
    end
  endgenerate

endmodule

// File: rtl/contador_cm_param.sv
// Echo-pulse width to packed-BCD centimetres with saturation and rising-edge arming.
// Define CONTADOR_CM_ROUND_EN to round the leftover half-cm instead of truncating.
module contador_cm_param
  import contador_cm_param_pkg::*;
#(
  parameter int CLK_PER_TICK = CLK_PER_TICK_DEF,
  parameter int TICKS_PER_CM = TICKS_PER_CM_DEF,
  parameter int N_DIGITS     = N_DIGITS_DEF,
  parameter int MAX_CM       = MAX_CM_DEF
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      pulso,
  output logic [BCD_W*N_DIGITS-1:0] digitos,
  output logic                      pronto,
  output logic                      overflow,
  output logic                      medindo
);

  localparam int DW = BCD_W * N_DIGITS;
  localparam int PW = $clog2(CLK_PER_TICK);
  localparam int SW = (TICKS_PER_CM > 1) ? $clog2(TICKS_PER_CM) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_PER_TICK - 1);
  localparam logic [SW-1:0] SUB_LAST   = SW'(TICKS_PER_CM - 1);
  localparam logic [DW-1:0] MAX_M1_BCD = DW'(to_bcd32(MAX_CM - 1));

  estado_t       state_reg;
  logic [PW-1:0] presc_reg;
  logic [SW-1:0] sub_reg;
  logic          pulso_d_reg;
  logic          armado_reg;
  logic          tick;
  logic          sub_last;
  logic          bcd_clear;
  logic          bcd_inc;

  assign tick      = (presc_reg == PRESC_LAST);
  assign sub_last  = (sub_reg == SUB_LAST);
  assign bcd_clear = (state_reg == PREPARACAO);

`ifdef CONTADOR_CM_ROUND_EN
  localparam logic [DW-1:0] MAX_BCD = DW'(to_bcd32(MAX_CM));
  logic round_up;
  assign round_up = ((2 * int'(sub_reg)) >= TICKS_PER_CM) && (digitos != MAX_BCD);
  assign bcd_inc  = (state_reg == INCREMENTA) || (state_reg == ARREDONDA);
`else
  assign bcd_inc  = (state_reg == INCREMENTA);
`endif

  bcd_counter_n #(
    .N_DIGITS(N_DIGITS)
  ) u_bcd (
    .clock(clock),
    .reset(reset),
    .clear(bcd_clear),
    .inc  (bcd_inc),
    .valor(digitos)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg   <= INICIAL;
      presc_reg   <= '0;
      sub_reg     <= '0;
      pulso_d_reg <= 1'b0;
      armado_reg  <= 1'b0;
      pronto      <= 1'b0;
      overflow    <= 1'b0;
      medindo     <= 1'b0;
    end else begin
      pulso_d_reg <= pulso;
      // A pulse already high out of reset must be seen low once before it can arm.
      armado_reg  <= armado_reg | ~pulso;
      pronto      <= 1'b0;
      unique case (state_reg)
        INICIAL: begin
          if (pulso && !pulso_d_reg && armado_reg) begin
            state_reg <= PREPARACAO;
            medindo   <= 1'b1;
          end
        end
        PREPARACAO: begin
          presc_reg <= '0;
          sub_reg   <= '0;
          overflow  <= 1'b0;
          state_reg <= CONTA;
        end
        CONTA: begin
          presc_reg <= tick ? '0 : presc_reg + 1'b1;
          if (tick) begin
            sub_reg <= sub_last ? '0 : sub_reg + 1'b1;
          end
          // A cm completed on the same edge that sees the pulse end still counts.
          if (tick && sub_last) begin
            state_reg <= INCREMENTA;
          end else if (!pulso) begin
`ifdef CONTADOR_CM_ROUND_EN
            if (round_up) begin
              state_reg <= ARREDONDA;
            end else begin
              state_reg <= FINAL;
              pronto    <= 1'b1;
              medindo   <= 1'b0;
            end
`else
            state_reg <= FINAL;
            pronto    <= 1'b1;
            medindo   <= 1'b0;
`endif
          end
        end
        INCREMENTA: begin
          presc_reg <= tick ? '0 : presc_reg + 1'b1;
          if (digitos == MAX_M1_BCD) begin
            state_reg <= SATURADO;
            overflow  <= 1'b1;
          end else if (pulso) begin
            state_reg <= CONTA;
          end else begin
            state_reg <= FINAL;
            pronto    <= 1'b1;
            medindo   <= 1'b0;
          end
        end
        SATURADO: begin
          if (!pulso) begin
            state_reg <= FINAL;
            pronto    <= 1'b1;
            medindo   <= 1'b0;
          end
        end
`ifdef CONTADOR_CM_ROUND_EN
        ARREDONDA: begin
          state_reg <= FINAL;
          pronto    <= 1'b1;
          medindo   <= 1'b0;
        end
`endif
        FINAL: begin
          state_reg <= INICIAL;
        end
        default: begin
          state_reg <= INICIAL;
          medindo   <= 1'b0;
        end
      endcase
    end
  end

endmodule
